// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: fetch FSM state encoding and instruction step size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  // Every instruction occupies one 32-bit word.
  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: jr > j > branch > sequential (wrapping inside the fetch window).
// Latency: purely combinational. Backpressure: none; the caller decides whether to load.
// Optional FETCH_ALIGN_CHECK_EN reports misaligned redirect targets instead of silently masking them.
module next_pc_mux import mips_pkg::*; #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  jump_reg,
  input  logic [DATA_WIDTH-1:0] jump_reg_addr,
  input  logic                  jump,
  input  logic [25:0]           jump_index,
  input  logic                  branch,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  misaligned_fault
);

  localparam logic [DATA_WIDTH-1:0] FIRST_PC = DATA_WIDTH'(RESET_VECTOR);
  localparam logic [DATA_WIDTH-1:0] LAST_PC  =
    DATA_WIDTH'(RESET_VECTOR + INSTR_BYTES * (MEMORY_DEPTH - 1));
  localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(INSTR_BYTES - 1);

  logic                  redirect;
  logic [DATA_WIDTH-1:0] raw_target;
  logic [DATA_WIDTH-1:0] seq_pc;

  assign pc_plus4 = pc + DATA_WIDTH'(INSTR_BYTES);

  // Pick the highest-priority redirect target and the wrapped sequential address.
  always_comb begin
    redirect   = jump_reg | jump | branch;
    raw_target = branch_target;
    if (jump_reg) begin
      raw_target = jump_reg_addr;
    end else if (jump) begin
      raw_target = {pc_plus4[DATA_WIDTH-1:28], jump_index, 2'b00};
    end
    seq_pc  = (pc == LAST_PC) ? FIRST_PC : pc_plus4;
    // Low address bits are dropped so the PC can never leave word alignment.
    next_pc = redirect ? (raw_target & WORD_MASK) : seq_pc;
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned_fault = redirect && (raw_target[1:0] != 2'b00);
`else
  assign misaligned_fault = 1'b0;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC register, BOOT/RUN/STALL/HALT control FSM and valid-fetch counter.
// Latency: PC updates one clk after controls are sampled; PCPlus4_o is combinational.
// Backpressure: Stall_i freezes the PC; FETCH_ALIGN_CHECK_EN halts on a misaligned redirect.
module fetch_unit import mips_pkg::*; #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 32,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall_i,
  input  logic                  Halt_i,
  input  logic                  Branch_i,
  input  logic [DATA_WIDTH-1:0] BranchTarget_i,
  input  logic                  Jump_i,
  input  logic [25:0]           JumpIndex_i,
  input  logic                  JumpReg_i,
  input  logic [DATA_WIDTH-1:0] JumpRegAddr_i,
  output logic [DATA_WIDTH-1:0] Address_o,
  output logic [DATA_WIDTH-1:0] PCPlus4_o,
  output logic                  FetchValid_o,
  output logic                  Halted_o,
  output logic [31:0]           FetchCount_o,
  output logic                  Misaligned_o
);

  fetch_state_t          state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt;
  logic [DATA_WIDTH-1:0] mux_next_pc;
  logic                  misaligned_fault;
  logic                  fault_set;
  logic [31:0]           fetch_count;
  logic                  misaligned_q;

  next_pc_mux #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_next_pc_mux (
    .pc               (pc),
    .jump_reg         (JumpReg_i),
    .jump_reg_addr    (JumpRegAddr_i),
    .jump             (Jump_i),
    .jump_index       (JumpIndex_i),
    .branch           (Branch_i),
    .branch_target    (BranchTarget_i),
    .pc_plus4         (PCPlus4_o),
    .next_pc          (mux_next_pc),
    .misaligned_fault (misaligned_fault)
  );

  // State register, PC, fetch counter and sticky misalignment flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_BOOT;
      pc           <= DATA_WIDTH'(RESET_VECTOR);
      fetch_count  <= 32'd0;
      misaligned_q <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == ST_RUN) begin
        fetch_count <= fetch_count + 32'd1;
      end
      if (fault_set) begin
        misaligned_q <= 1'b1;
      end
    end
  end

  // Next state and next PC; controls only matter in RUN and STALL.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fault_set = 1'b0;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (Halt_i) begin
          state_nxt = ST_HALT;
        end else if (Stall_i) begin
          state_nxt = ST_STALL;
        end else if (misaligned_fault) begin
          // Keep the last good PC so the offending target never reaches memory.
          state_nxt = ST_HALT;
          fault_set = 1'b1;
        end else begin
          pc_nxt = mux_next_pc;
        end
      end
      ST_STALL: begin
        if (Halt_i) begin
          state_nxt = ST_HALT;
        end else if (!Stall_i) begin
          state_nxt = ST_RUN;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign Address_o    = pc;
  assign FetchValid_o = (state == ST_RUN);
  assign Halted_o     = (state == ST_HALT);
  assign FetchCount_o = fetch_count;
  assign Misaligned_o = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs a reference model.
// Latency: checks sampled on the falling clock edge, inputs driven there too.
// Backpressure: exercises Stall_i/Halt_i; FETCH_ALIGN_CHECK_EN selects the expected misalignment behaviour.
module tb_fetch_unit;

  localparam int unsigned DW  = 32;
  localparam int unsigned MD  = 32;
  localparam int unsigned RV  = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          Stall_i, Halt_i, Branch_i, Jump_i, JumpReg_i;
  logic [DW-1:0] BranchTarget_i, JumpRegAddr_i;
  logic [25:0]   JumpIndex_i;
  logic [DW-1:0] Address_o, PCPlus4_o;
  logic          FetchValid_o, Halted_o, Misaligned_o;
  logic [31:0]   FetchCount_o;

  int checks = 0;
  int errors = 0;

  // Reference model: what the fetch stage should be doing, in plain terms.
  logic [31:0] m_pc;
  bit          m_booting, m_halted, m_stalled, m_mis;
  logic [31:0] m_cnt;

  fetch_unit #(.DATA_WIDTH(DW), .MEMORY_DEPTH(MD), .RESET_VECTOR(RV)) dut (
    .clk            (clk),
    .reset          (reset),
    .Stall_i        (Stall_i),
    .Halt_i         (Halt_i),
    .Branch_i       (Branch_i),
    .BranchTarget_i (BranchTarget_i),
    .Jump_i         (Jump_i),
    .JumpIndex_i    (JumpIndex_i),
    .JumpReg_i      (JumpReg_i),
    .JumpRegAddr_i  (JumpRegAddr_i),
    .Address_o      (Address_o),
    .PCPlus4_o      (PCPlus4_o),
    .FetchValid_o   (FetchValid_o),
    .Halted_o       (Halted_o),
    .FetchCount_o   (FetchCount_o),
    .Misaligned_o   (Misaligned_o)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    Stall_i = 0; Halt_i = 0; Branch_i = 0; Jump_i = 0; JumpReg_i = 0;
    BranchTarget_i = '0; JumpRegAddr_i = '0; JumpIndex_i = '0;
  endtask

  task automatic model_reset();
    m_pc = RV; m_booting = 1; m_halted = 0; m_stalled = 0; m_mis = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] t;
    logic [31:0] pc4;
    bit redirect;
    if (m_booting) begin
      m_booting = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (m_stalled) begin
      if (Halt_i) m_halted = 1;
      else if (!Stall_i) m_stalled = 0;
    end else begin
      m_cnt = m_cnt + 1;
      if (Halt_i) m_halted = 1;
      else if (Stall_i) m_stalled = 1;
      else begin
        pc4 = m_pc + 4;
        redirect = JumpReg_i || Jump_i || Branch_i;
        if (JumpReg_i) t = JumpRegAddr_i;
        else if (Jump_i) t = {pc4[31:28], JumpIndex_i, 2'b00};
        else if (Branch_i) t = BranchTarget_i;
        else t = (m_pc == RV + 4 * (MD - 1)) ? RV : pc4;
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect && t[1:0] != 2'b00) begin
          m_mis = 1; m_halted = 1;
        end else begin
          m_pc = t;
        end
`else
        m_pc = redirect ? (t & 32'hFFFF_FFFC) : t;
`endif
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  // Reset, leave BOOT, then step sequentially until PC = 4*n.
  task automatic bring_to_pc(input int n);
    do_reset();
    tick();
    repeat (n) tick();
  endtask

  task automatic test_reset();
    bring_to_pc(3);
    #2 reset = 1;
    model_reset();
    #1;
    checks++; if (Address_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", Address_o); end
    checks++; if (FetchValid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", FetchValid_o); end
    checks++; if (Halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", Halted_o); end
    checks++; if (FetchCount_o !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", FetchCount_o); end
    checks++; if (Misaligned_o !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", Misaligned_o); end
    @(negedge clk);
    reset = 0;
    checks++; if (FetchValid_o !== 1'b0 || Address_o !== 32'h0) begin
      errors++; $display("FAIL boot_cycle: valid %b addr %h want 0 / 0", FetchValid_o, Address_o);
    end
  endtask

  task automatic test_sequential_wrap();
    logic [31:0] exp_addr;
    do_reset();
    tick();
    for (int i = 0; i <= 32; i++) begin
      exp_addr = (i % 32) * 4;
      checks++; if (Address_o !== exp_addr || FetchValid_o !== 1'b1) begin
        errors++; $display("FAIL seq_addr[%0d]: addr %h valid %b want %h / 1", i, Address_o, FetchValid_o, exp_addr);
      end
      checks++; if (PCPlus4_o !== exp_addr + 32'd4) begin
        errors++; $display("FAIL seq_pc4[%0d]: got %h want %h", i, PCPlus4_o, exp_addr + 32'd4);
      end
      checks++; if (FetchCount_o !== 32'(i)) begin
        errors++; $display("FAIL seq_count[%0d]: got %0d want %0d", i, FetchCount_o, i);
      end
      if (i < 32) tick();
    end
  endtask

  task automatic test_priority();
    bring_to_pc(4);
    Jump_i = 1; JumpIndex_i = 26'h8; Branch_i = 1; BranchTarget_i = 32'h40;
    tick();
    clear_inputs();
    checks++; if (Address_o !== 32'h20) begin errors++; $display("FAIL jump_over_branch: got %h want 20", Address_o); end
    bring_to_pc(2);
    JumpReg_i = 1; JumpRegAddr_i = 32'h30; Jump_i = 1; JumpIndex_i = 26'h10;
    tick();
    clear_inputs();
    checks++; if (Address_o !== 32'h30) begin errors++; $display("FAIL jr_over_jump: got %h want 30", Address_o); end
    Branch_i = 1; BranchTarget_i = 32'h54;
    tick();
    clear_inputs();
    checks++; if (Address_o !== 32'h54) begin errors++; $display("FAIL branch_taken: got %h want 54", Address_o); end
  endtask

  task automatic test_stall();
    bring_to_pc(2);
    Stall_i = 1; Branch_i = 1; BranchTarget_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (Address_o !== 32'h08 || FetchValid_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: addr %h valid %b want 08 / 0", i, Address_o, FetchValid_o);
      end
    end
    clear_inputs();
    tick();
    checks++; if (Address_o !== 32'h08 || FetchValid_o !== 1'b1) begin
      errors++; $display("FAIL stall_exit: addr %h valid %b want 08 / 1", Address_o, FetchValid_o);
    end
    tick();
    checks++; if (Address_o !== 32'h0C) begin errors++; $display("FAIL stall_resume: got %h want 0c", Address_o); end
  endtask

  task automatic test_halt();
    bring_to_pc(5);
    Halt_i = 1; Stall_i = 1;
    tick();
    clear_inputs();
    checks++; if (Halted_o !== 1'b1 || Address_o !== 32'h14) begin
      errors++; $display("FAIL halt_enter: halted %b addr %h want 1 / 14", Halted_o, Address_o);
    end
    for (int i = 0; i < 6; i++) begin
      Branch_i = 1; BranchTarget_i = 32'h40; Jump_i = i[0]; Stall_i = i[1];
      tick();
    end
    clear_inputs();
    checks++; if (Address_o !== 32'h14 || Halted_o !== 1'b1 || FetchValid_o !== 1'b0) begin
      errors++; $display("FAIL halt_hold: addr %h halted %b valid %b want 14 / 1 / 0", Address_o, Halted_o, FetchValid_o);
    end
    #2 reset = 1;
    model_reset();
    #1;
    checks++; if (Address_o !== 32'h0 || Halted_o !== 1'b0) begin
      errors++; $display("FAIL halt_reset: addr %h halted %b want 0 / 0", Address_o, Halted_o);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_misaligned();
    bring_to_pc(3);
    JumpReg_i = 1; JumpRegAddr_i = 32'h1A;
    tick();
    clear_inputs();
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (Misaligned_o !== 1'b1 || Halted_o !== 1'b1 || Address_o !== 32'h0C) begin
      errors++; $display("FAIL misaligned: mis %b halted %b addr %h want 1 / 1 / 0c", Misaligned_o, Halted_o, Address_o);
    end
`else
    checks++; if (Misaligned_o !== 1'b0 || Halted_o !== 1'b0 || Address_o !== 32'h18) begin
      errors++; $display("FAIL misaligned: mis %b halted %b addr %h want 0 / 0 / 18", Misaligned_o, Halted_o, Address_o);
    end
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      checks++; if (Address_o !== m_pc || PCPlus4_o !== m_pc + 32'd4 ||
                    FetchValid_o !== (!m_booting && !m_halted && !m_stalled) ||
                    Halted_o !== m_halted || FetchCount_o !== m_cnt || Misaligned_o !== m_mis) begin
        errors++;
        $display("FAIL random[%0d]: addr %h pc4 %h v %b h %b cnt %0d mis %b want addr %h v %b h %b cnt %0d mis %b",
                 c, Address_o, PCPlus4_o, FetchValid_o, Halted_o, FetchCount_o, Misaligned_o,
                 m_pc, (!m_booting && !m_halted && !m_stalled), m_halted, m_cnt, m_mis);
      end
      if (c % 100 == 99) begin
        do_reset();
      end else begin
        Stall_i        = ($urandom_range(0, 99) < 20);
        Halt_i         = ($urandom_range(0, 99) < 2);
        JumpReg_i      = ($urandom_range(0, 99) < 10);
        Jump_i         = ($urandom_range(0, 99) < 10);
        Branch_i       = ($urandom_range(0, 99) < 15);
        JumpIndex_i    = 26'($urandom_range(0, 63));
        BranchTarget_i = 32'(4 * $urandom_range(0, MD - 1)) | (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
        JumpRegAddr_i  = 32'(4 * $urandom_range(0, MD - 1)) | (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
        tick();
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    model_reset();
    test_reset();
    test_sequential_wrap();
    test_priority();
    test_stall();
    test_halt();
    test_misaligned();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, address/instruction width.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 32, program memory words; fetch window = MEMORY_DEPTH words.
REQ-003 SHALL have parameter RESET_VECTOR, default 0, byte address of first instruction; word-aligned.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, both listed first.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port Stall_i, input, 1, hold PC this cycle.
REQ-008 SHALL have port Halt_i, input, 1, enter HALT.
REQ-009 SHALL have port Branch_i, input, 1, take BranchTarget_i.
REQ-010 SHALL have port BranchTarget_i, input, DATA_WIDTH, branch byte address.
REQ-011 SHALL have port Jump_i, input, 1, take J-format target.
REQ-012 SHALL have port JumpIndex_i, input, 26, instr_index field.
REQ-013 SHALL have port JumpReg_i, input, 1, take JumpRegAddr_i (jr).
REQ-014 SHALL have port JumpRegAddr_i, input, DATA_WIDTH, register target.
REQ-015 SHALL have port Address_o, output, DATA_WIDTH, current PC to program memory.
REQ-016 SHALL have port PCPlus4_o, output, DATA_WIDTH, Address_o+4, combinational.
REQ-017 SHALL have port FetchValid_o, output, 1, Address_o is a live fetch this cycle.
REQ-018 SHALL have port Halted_o, output, 1, state is HALT.
REQ-019 SHALL have port FetchCount_o, output, 32, count of valid fetches.
REQ-020 SHALL have port Misaligned_o, output, 1, sticky misaligned-target flag.

Function
REQ-021 SHALL implement states BOOT, RUN, STALL, HALT; FetchValid_o=1 only in RUN.
REQ-022 SHALL go BOOT->RUN unconditionally one cycle after reset deasserts.
REQ-023 SHALL, in RUN, update PC every clk: priority Halt_i > Stall_i > JumpReg_i > Jump_i > Branch_i > sequential.
REQ-024 SHALL compute jump target as {PCPlus4_o[31:28], JumpIndex_i, 2'b00}.
REQ-025 SHALL wrap sequential PC from RESET_VECTOR+4*(MEMORY_DEPTH-1) to RESET_VECTOR.
REQ-026 SHALL, on Stall_i in RUN, hold PC, go STALL, ignore redirect inputs that cycle; STALL->RUN when Stall_i low, PC unchanged.
REQ-027 SHALL enter HALT from RUN/STALL on Halt_i; HALT holds PC, exits only on reset.
REQ-028 SHALL ignore all control inputs in BOOT and HALT.
REQ-029 SHALL increment FetchCount_o on each RUN cycle, wrapping modulo 2^32.

Reset
REQ-030 SHALL, on reset, set Address_o=RESET_VECTOR, state BOOT, FetchValid_o=0, Halted_o=0, FetchCount_o=0, Misaligned_o=0, immediately and regardless of state.

Configuration
REQ-031 SHALL, with FETCH_ALIGN_CHECK_EN defined, set Misaligned_o and enter HALT (PC holding offending-free old value) when a selected redirect target has bits[1:0]!=0.
REQ-032 SHALL, without FETCH_ALIGN_CHECK_EN, force target bits[1:0] to 0, keep Misaligned_o tied 0.

Structure
REQ-033 SHALL place state encoding and the 4-byte instruction-step constant in shared package mips_pkg.
REQ-034 SHALL implement next-PC selection as sub-module next_pc_mux; state register and counter in fetch_unit.

Verification
REQ-035 Reset release, no controls -> cycle1 BOOT Address_o=0 FetchValid_o=0; then 0,4,8,... FetchValid_o=1.
REQ-036 Run 32 cycles, MEMORY_DEPTH=32 -> Address_o 0x7C followed by 0x00; FetchCount_o=32.
REQ-037 At PC=0x10 assert Jump_i, JumpIndex_i=0x8, and Branch_i, BranchTarget_i=0x40 together -> next Address_o=0x20.
REQ-038 At PC=0x08 assert Stall_i 3 cycles plus Branch_i -> Address_o stays 0x08, FetchValid_o=0, then resumes 0x0C.
REQ-039 Halt_i with Stall_i at PC=0x14 -> HALT, Address_o=0x14 forever, Halted_o=1; reset mid-HALT -> Address_o=0 same cycle.
REQ-040 JumpReg_i, JumpRegAddr_i=0x1A -> with macro: Misaligned_o=1, HALT, Address_o unchanged; without: Address_o=0x18.
